// File: rtl/uart_pkg.sv
// Shared UART definitions: clocking constants, data width and the transmit FSM state type.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_CLK_HZ           = 10_000_000;
    localparam int unsigned UART_BAUD             = 9600;
    localparam int unsigned UART_CLKS_PER_BIT_DEF = 1042;
    localparam int unsigned UART_DATA_W           = 8;
    localparam int unsigned UART_BITCNT_W         = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLEAR
    } uart_tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_CLEAR
    } uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle with tick_o.
// Shared by the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic clk_i,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit engine: serialises the latched byte 8N1 (8E1 with UART_TX_PARITY_EN defined)
// and pulses clr_send_o for one cycle after the stop bit to clear the control register's send bit.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   send_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   clr_send_o
);

    uart_tx_state_e             state_q, state_d;
    logic [UART_DATA_W-1:0]     shift_q, shift_d;
    logic [UART_BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                       tx_q, tx_d;
    logic                       baud_tick;
    logic                       baud_clr;
`ifdef UART_TX_PARITY_EN
    logic                       par_q, par_d;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk_i),
        .rst   (rst),
        .clr_i (baud_clr),
        .tick_o(baud_tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (send_i) begin
                    state_d   = ST_START;
                    shift_d   = data_i;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^data_i;
`endif
                end
            end
            ST_START: begin
                if (baud_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + UART_BITCNT_W'(1);
                    if (bit_cnt_q == '1) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_tick) state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Line level is computed from the next state so tx_o comes straight from a flop.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        baud_clr = (state_d != state_q) || (state_q == ST_IDLE);
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign clr_send_o = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl at CLKS_PER_BIT=4; define UART_TX_PARITY_EN for the 8E1 build.
module tb_uart_tx_ctrl;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk_i  = 1'b0;
    logic       rst    = 1'b0;
    logic       send_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       tx_o;
    logic       busy_o;
    logic       clr_send_o;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .send_i    (send_i),
        .data_i    (data_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .clr_send_o(clr_send_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic tx;
        logic busy;
        logic clr;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        int         mutate_at;
        logic [7:0] exp_rx;
        logic       exp_par;
    } vec_t;

    obs_t       exp_q[$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         fcyc    = -1;
    int         clr_cnt = 0;
    int         blen    = 0;
    logic [7:0] rx      = 8'h00;
    logic       par_obs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected per-cycle line/busy/clear values for one frame, starting the cycle after the latch edge.
    task automatic push_frame(input logic [7:0] d);
        logic v;
        for (int b = 0; b < int'(NBITS); b++) begin
            if (b == 0)                      v = 1'b0;
            else if (b <= 8)                 v = d[b-1];
            else if (b == int'(NBITS) - 1)   v = 1'b1;
            else                             v = ^d;
            for (int c = 0; c < int'(CPB); c++) exp_q.push_back('{v, 1'b1, 1'b0});
        end
        exp_q.push_back('{1'b1, 1'b1, 1'b1});
        fcyc = -1;
        rx   = 8'h00;
        blen = 0;
    endtask

    // One cycle: compare against the scoreboard (idle when empty); also models the control register.
    task automatic cycle_check(input string name);
        obs_t e;
        obs_t a;
        @(negedge clk_i);
        a = '{tx_o, busy_o, clr_send_o};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            fcyc++;
            for (int i = 0; i < 8; i++)
                if (fcyc == int'(CPB) * (1 + i) + int'(CPB) / 2) rx[i] = tx_o;
            if (fcyc == int'(CPB) * 9 + int'(CPB) / 2) par_obs = tx_o;
        end else begin
            e = '{1'b1, 1'b0, 1'b0};
        end
        check(name, 32'(a), 32'(e));
        if (busy_o === 1'b1 && clr_send_o === 1'b0) blen++;
        if (clr_send_o === 1'b1) begin
            clr_cnt++;
            send_i = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int mutate_at);
        data_i = d;
        send_i = 1'b1;
        push_frame(d);
        while (exp_q.size() > 0) begin
            cycle_check("frame");
            if (fcyc == mutate_at) begin
                data_i = 8'hFF;
                send_i = 1'b0;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h55, -1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 12, 8'hA3, 1'b0};
        vecs[2] = '{8'h07, -1, 8'h07, 1'b1};
        vecs[3] = '{8'h03, -1, 8'h03, 1'b0};
        vecs[4] = '{8'h00, -1, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, -1, 8'hFF, 1'b0};

        rst = 1'b0;
        repeat (3) @(negedge clk_i);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) cycle_check("reset_idle");

        foreach (vecs[k]) begin
            clr_cnt = 0;
            run_frame(vecs[k].data, vecs[k].mutate_at);
            for (int i = 0; i < 3; i++) cycle_check("post_idle");
            check("rx_data", 32'(rx), 32'(vecs[k].exp_rx));
            check("clr_pulses", 32'(clr_cnt), 32'd1);
            check("frame_len", 32'(blen), 32'(NBITS * CPB));
`ifdef UART_TX_PARITY_EN
            check("parity", 32'(par_obs), 32'(vecs[k].exp_par));
`endif
        end

        // Back-to-back: re-set send_i in the first idle cycle after the clear pulse.
        clr_cnt = 0;
        run_frame(8'h3C, -1);
        cycle_check("b2b_gap");
        run_frame(8'hC5, -1);
        check("b2b_rx2", 32'(rx), 32'h0000_00C5);
        cycle_check("b2b_end");
        check("b2b_clr_pulses", 32'(clr_cnt), 32'd2);

        // Reset during data bit 3; send_i stays set so a fresh frame follows release.
        clr_cnt = 0;
        data_i  = 8'h5A;
        send_i  = 1'b1;
        push_frame(8'h5A);
        while (fcyc < 17) cycle_check("pre_rst");
        rst = 1'b0;
        exp_q.delete();
        cycle_check("rst_mid");
        rst = 1'b1;
        check("rst_no_clr", 32'(clr_cnt), 32'd0);
        check("rst_send_held", 32'(send_i), 32'd1);
        run_frame(8'h5A, -1);
        check("rst_refire_rx", 32'(rx), 32'h0000_005A);
        check("rst_refire_clr", 32'(clr_cnt), 32'd1);
        for (int i = 0; i < 3; i++) cycle_check("rst_post_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit engine for the peripheral bus; it is the consumer end of the UART control register's send bit. When the send bit is set, it latches the data byte and serialises it 8N1 (or 8E1, see Configuration) on `tx_o`. At frame end it pulses `clr_send_o`, which drives the control register's second write-enable with data 0 and clears the send bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1042: clk_i cycles per bit (10 MHz / 9600 baud); legal range ≥ 2.

Ports:
- `clk_i`  in  1  system clock, 10 MHz
- `rst`  in  1  reset rst, synchronous, active-low; clock clk_i.
- `send_i`  in  1  send bit from the UART control register (level)
- `data_i`  in  8  byte to transmit, from the TX data register
- `tx_o`  out  1  serial line, idle high
- `busy_o`  out  1  high while a frame is in progress, including the clear cycle
- `clr_send_o`  out  1  one-cycle pulse; wires to the control register's we_2 (d_2 tied 0)

## Operation
- States: IDLE, START, DATA, PARITY (only if compiled in), STOP, CLEAR.
- IDLE: `tx_o`=1, `busy_o`=0. If `send_i`=1 at an edge: latch `data_i` into the shift register, clear the bit counter (3 bits) and the baud counter, and go to START.
- START: `tx_o`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx_o`=shift[0], LSB first; each bit lasts CLKS_PER_BIT cycles. After each bit, shift right and increment the bit counter. After bit 7 (counter wraps 7→0), go to PARITY or STOP.
- STOP: `tx_o`=1 for CLKS_PER_BIT cycles, then go to CLEAR.
- CLEAR: `clr_send_o`=1, `tx_o`=1, `busy_o`=1 for exactly one cycle, then go to IDLE unconditionally.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1. The bit-end tick fires at CLKS_PER_BIT-1; the counter reloads 0 on every state change.
- `send_i` dropping mid-frame is ignored; the frame completes and CLEAR still pulses.
- `data_i` changes after the latch edge are ignored.
- `tx_o` is registered (glitch-free).

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `tx_o`=1, `busy_o`=0, `clr_send_o`=0, shift register=0, counters=0. Reset overrides everything, including mid-frame; the aborted frame gets no `clr_send_o`, so the send bit stays set and software must clear it.
- Latch edge E0 (IDLE, `send_i`=1): `tx_o`=0 and `busy_o`=1 from the cycle after E0.
- Frame length in cycles, start of start bit through end of stop bit: 10·CLKS_PER_BIT (8N1) or 11·CLKS_PER_BIT (parity enabled).
- `clr_send_o` is high during the single cycle after the stop bit. The control register clears on that same closing edge, so IDLE sees `send_i`=0 and no frame is retriggered.
- Back-to-back: if software sets `send_i` again, the earliest next latch is the first IDLE cycle. This gives a minimum 1-cycle idle-high gap between frames.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state follows DATA and drives even parity (XOR of the latched byte) for CLKS_PER_BIT cycles. Frame is 8E1, 11 bits.
- Undefined: the PARITY state and the parity logic are absent; DATA goes straight to STOP. Frame is 8N1, 10 bits.

## Structure
- Package `uart_pkg`:
  - state enum typedef `uart_tx_state_e`
  - constants `UART_CLK_HZ`=10_000_000, `UART_BAUD`=9600, `UART_CLKS_PER_BIT_DEF`=1042
  - localparam for data width (8)
- Sub-module `uart_baud_cnt`: parameterised cycle counter with synchronous clear and a one-cycle `tick_o` at CLKS_PER_BIT-1. The receiver reuses it.
- Top holds the FSM, shift register, bit counter and parity XOR.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset then idle: hold `rst`=0 for 3 cycles, release → `tx_o`=1, `busy_o`=0, `clr_send_o`=0, stable for 50 cycles with `send_i`=0.
- Send 0x55 (8N1): `send_i`=1 → `tx_o` pattern 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then `clr_send_o` high exactly 1 cycle. Model the control register so `send_i` falls afterwards; no second frame follows.
- Send 0xA3 while changing `data_i` to 0xFF and dropping `send_i` mid-frame → data bits read LSB-first are 1,1,0,0,0,1,0,1 (0xA3); frame completes; `clr_send_o` pulses once.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 → next cycle `tx_o`=1, `busy_o`=0; `clr_send_o` never pulses; after release with `send_i` still 1, a fresh full frame starts.
- Back-to-back: software re-sets `send_i` in the cycle after `clr_send_o` → the second start bit begins after exactly one idle-high cycle; two clean frames, two `clr_send_o` pulses.
- With `UART_TX_PARITY_EN` defined: send 0x07 → parity bit 1 (three ones), frame is 44 cycles; send 0x03 → parity bit 0.
